// File: rtl/sh7604_mac_seq.sv
// sh7604_mac_seq: issues CE_R-aligned write/read beats to the SH7604 MAC unit
// for one decoded MAC-class command, and returns STS read data to the core.
module sh7604_mac_seq (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        RES_N,
   input  logic        CMD_REQ,
   input  logic [3:0]  CMD_OP,
   input  logic [1:0]  CMD_SEL,
   input  logic [31:0] CMD_A,
   input  logic [31:0] CMD_B,
   input  logic [1:0]  CMD_AA,
   input  logic [1:0]  CMD_AB,
   input  logic        CMD_S,
   output logic        CMD_ACK,
   output logic        BUSY,
   output logic [31:0] RES_DATA,
   output logic        RES_VALID,
   output logic [1:0]  MAC_SEL,
   output logic [3:0]  MAC_OP,
   output logic        MAC_S,
   output logic        MAC_WE,
   output logic [31:0] MAC_DO,
   output logic [31:0] MAC_A,
   input  logic [31:0] MAC_DI
);
   localparam logic [1:0] IDLE = 2'd0, B1 = 2'd1, B2 = 2'd2, RD = 2'd3;
   logic [1:0]  state;
   logic [31:0] b_q;
   logic [1:0]  ab_q;
   logic        lds, mulw, clr, two, sts, vld;
   always_comb begin
      lds  = CMD_OP == 4'b0100 || CMD_OP == 4'b1000;
      mulw = CMD_OP == 4'b0110 || CMD_OP == 4'b0111;
      clr  = CMD_OP == 4'b1111;
      two  = CMD_OP == 4'b0001 || CMD_OP == 4'b0010 || CMD_OP == 4'b0011 ||
             CMD_OP == 4'b1001 || CMD_OP == 4'b1011;
      sts  = CMD_OP == 4'b0000;
      vld  = lds || mulw || clr || two || sts;
   end
   assign BUSY = state != IDLE;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         b_q       <= '0;
         ab_q      <= '0;
         CMD_ACK   <= 1'b0;
         RES_DATA  <= '0;
         RES_VALID <= 1'b0;
         MAC_SEL   <= '0;
         MAC_OP    <= '0;
         MAC_S     <= 1'b0;
         MAC_WE    <= 1'b0;
         MAC_DO    <= '0;
         MAC_A     <= '0;
      end else if (!RES_N) begin
         // soft reset aborts mid-command; a loaded MA operand is left without an execute beat
         state     <= IDLE;
         b_q       <= '0;
         ab_q      <= '0;
         CMD_ACK   <= 1'b0;
         RES_DATA  <= '0;
         RES_VALID <= 1'b0;
         MAC_SEL   <= '0;
         MAC_OP    <= '0;
         MAC_S     <= 1'b0;
         MAC_WE    <= 1'b0;
         MAC_DO    <= '0;
         MAC_A     <= '0;
      end else begin
         CMD_ACK   <= 1'b0;
         RES_VALID <= 1'b0;
         if (CE_R) begin
            case (state)
               IDLE: if (CMD_REQ) begin
                  CMD_ACK <= 1'b1;
                  if (vld) begin
                     b_q     <= CMD_B;
                     ab_q    <= CMD_AB;
                     MAC_OP  <= CMD_OP;
                     MAC_S   <= CMD_S;
                     MAC_SEL <= two ? 2'b01 : mulw ? 2'b10 : clr ? 2'b11 : CMD_SEL;
                     MAC_WE  <= !sts;
                     MAC_DO  <= mulw ? {CMD_B[15:0], CMD_A[15:0]} : CMD_A;
                     MAC_A   <= two ? {30'b0, CMD_AA} : 32'b0;
                     state   <= two ? B1 : sts ? RD : B2;
                  end
               end
               B1: begin
                  MAC_SEL <= 2'b10;
                  MAC_DO  <= b_q;
                  MAC_A   <= {30'b0, ab_q};
                  state   <= B2;
               end
               B2: begin
                  MAC_SEL <= 2'b00;
                  MAC_WE  <= 1'b0;
                  state   <= IDLE;
               end
               default: begin
                  RES_DATA  <= MAC_DI;
                  RES_VALID <= 1'b1;
                  MAC_SEL   <= 2'b00;
                  state     <= IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sh7604_mac_seq.sv
// tb_sh7604_mac_seq: directed vectors for sh7604_mac_seq against a small
// behavioural multiplier that answers the issued beats.
module tb_sh7604_mac_seq;
   logic        CLK = 1'b0, RST_N, CE_R, RES_N, CMD_REQ, CMD_S;
   logic [3:0]  CMD_OP;
   logic [1:0]  CMD_SEL, CMD_AA, CMD_AB;
   logic [31:0] CMD_A, CMD_B;
   logic        CMD_ACK, BUSY, RES_VALID, MAC_S, MAC_WE;
   logic [31:0] RES_DATA, MAC_DO, MAC_A, MAC_DI;
   logic [1:0]  MAC_SEL;
   logic [3:0]  MAC_OP;
   int checks = 0, failures = 0;

   sh7604_mac_seq dut (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N), .CMD_REQ(CMD_REQ),
      .CMD_OP(CMD_OP), .CMD_SEL(CMD_SEL), .CMD_A(CMD_A), .CMD_B(CMD_B),
      .CMD_AA(CMD_AA), .CMD_AB(CMD_AB), .CMD_S(CMD_S), .CMD_ACK(CMD_ACK),
      .BUSY(BUSY), .RES_DATA(RES_DATA), .RES_VALID(RES_VALID), .MAC_SEL(MAC_SEL),
      .MAC_OP(MAC_OP), .MAC_S(MAC_S), .MAC_WE(MAC_WE), .MAC_DO(MAC_DO),
      .MAC_A(MAC_A), .MAC_DI(MAC_DI)
   );

   always #5 CLK = ~CLK;

   // multiplier model: samples the beat present at each CE_R edge
   logic [31:0] mach = 0, macl = 0, ma = 0;
   logic [1:0]  maa = 0;
   logic [63:0] p;
   logic [31:0] hp;
   logic [32:0] sm;
   logic [15:0] hx, hy;
   assign MAC_DI = MAC_SEL[1] ? mach : macl;
   always @(posedge CLK) begin
      if (CE_R && MAC_WE) begin
         case (MAC_OP)
            4'b0100, 4'b1000: begin
               if (MAC_SEL[0]) macl <= MAC_DO;
               if (MAC_SEL[1]) mach <= MAC_DO;
            end
            4'b1111: begin mach <= 0; macl <= 0; end
            4'b0110: macl <= {16'b0, MAC_DO[31:16]} * {16'b0, MAC_DO[15:0]};
            4'b0111: macl <= {{16{MAC_DO[31]}}, MAC_DO[31:16]} * {{16{MAC_DO[15]}}, MAC_DO[15:0]};
            default:
               if (MAC_SEL == 2'b01) begin
                  ma <= MAC_DO; maa <= MAC_A[1:0];
               end else if (MAC_SEL == 2'b10) begin
                  case (MAC_OP)
                     4'b0001: macl <= ma * MAC_DO;
                     4'b0010: begin p = {32'b0, ma} * {32'b0, MAC_DO}; {mach, macl} <= p; end
                     4'b0011: begin
                        p = {{32{ma[31]}}, ma} * {{32{MAC_DO[31]}}, MAC_DO};
                        {mach, macl} <= p;
                     end
                     4'b1011: begin
                        hx = maa[1] ? ma[15:0] : ma[31:16];
                        hy = MAC_A[1] ? MAC_DO[15:0] : MAC_DO[31:16];
                        hp = {{16{hx[15]}}, hx} * {{16{hy[15]}}, hy};
                        sm = {macl[31], macl} + {hp[31], hp};
                        if (!MAC_S) {mach, macl} <= {mach, macl} + {{32{hp[31]}}, hp};
                        else if (sm[32] != sm[31]) begin
                           macl <= sm[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                           mach <= mach | 32'd1;
                        end else macl <= sm[31:0];
                     end
                     default: ;
                  endcase
               end
         endcase
      end
   end

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [1:0]  sel;
      logic [31:0] a, b;
      logic [1:0]  aa, ab;
      logic        s;
      logic [1:0]  nb;
      logic [1:0]  sel1;
      logic        we1, chkdo;
      logic [31:0] do1, res;
   } vec_t;

   function automatic vec_t mk(input string n, input logic [3:0] op, input logic [1:0] sel,
                               input logic [31:0] a, input logic [31:0] b, input logic [1:0] aa,
                               input logic [1:0] ab, input logic s, input logic [1:0] nb,
                               input logic [1:0] sel1, input logic we1, input logic chkdo,
                               input logic [31:0] do1, input logic [31:0] res);
      vec_t v;
      v.name = n; v.op = op; v.sel = sel; v.a = a; v.b = b; v.aa = aa; v.ab = ab; v.s = s;
      v.nb = nb; v.sel1 = sel1; v.we1 = we1; v.chkdo = chkdo; v.do1 = do1; v.res = res;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // nb: 0 dropped, 1 single beat, 2 two beats, 3 STS read; entered and left at a negedge
   task automatic run_cmd(input vec_t v);
      CMD_OP = v.op; CMD_SEL = v.sel; CMD_A = v.a; CMD_B = v.b;
      CMD_AA = v.aa; CMD_AB = v.ab; CMD_S = v.s; CMD_REQ = 1'b1;
      @(negedge CLK);
      CMD_REQ = 1'b0;
      chk({v.name, ".ack"}, 32'(CMD_ACK), 1);
      chk({v.name, ".rv0"}, 32'(RES_VALID), 0);
      chk({v.name, ".we1"}, 32'(MAC_WE), 32'(v.nb == 0 ? 1'b0 : v.we1));
      chk({v.name, ".busy"}, 32'(BUSY), 32'(v.nb != 0));
      if (v.nb != 0) begin
         chk({v.name, ".sel1"}, 32'(MAC_SEL), 32'(v.sel1));
         chk({v.name, ".op"}, 32'({MAC_S, MAC_OP}), 32'({v.s, v.op}));
         if (v.chkdo) chk({v.name, ".do1"}, MAC_DO, v.do1);
         if (v.nb == 2) chk({v.name, ".a1"}, MAC_A, {30'b0, v.aa});
      end
      CMD_A = 32'hDEAD_BEEF; CMD_B = 32'hCAFE_F00D; CMD_AB = 2'b01;
      if (v.nb == 2) begin
         @(negedge CLK);
         chk({v.name, ".sel2"}, 32'({MAC_WE, MAC_SEL}), 32'b110);
         chk({v.name, ".do2"}, MAC_DO, v.b);
         chk({v.name, ".a2"}, MAC_A, {30'b0, v.ab});
         chk({v.name, ".ack0"}, 32'(CMD_ACK), 0);
      end
      if (v.nb == 3) begin
         @(negedge CLK);
         chk({v.name, ".rv"}, 32'(RES_VALID), 1);
         chk({v.name, ".res"}, RES_DATA, v.res);
         chk({v.name, ".idle"}, 32'({BUSY, MAC_SEL}), 0);
      end else if (v.nb != 0) begin
         @(negedge CLK);
         chk({v.name, ".end"}, 32'({BUSY, MAC_WE, MAC_SEL}), 0);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".ctl"}, 32'({CMD_ACK, BUSY, RES_VALID, MAC_SEL, MAC_OP, MAC_S, MAC_WE}), 0);
      chk({nm, ".do"}, MAC_DO, 0);
      chk({nm, ".a"}, MAC_A, 0);
      chk({nm, ".res"}, RES_DATA, 0);
   endtask

   vec_t v[13];
   vec_t sts_l;

   initial begin
      int acks, wide, bad, ackbusy;
      logic [1:0] sel_prev;
      logic ack_prev, ce_prev, busy_prev;
      v[0]  = mk("clrmac",   4'hF, 2'b00, 0, 0, 0, 0, 0, 1, 2'b11, 1, 0, 0, 0);
      v[1]  = mk("dmuls",    4'h3, 2'b00, 32'hFFFF_FFFE, 3, 0, 0, 0, 2, 2'b01, 1, 1, 32'hFFFF_FFFE, 0);
      v[2]  = mk("sts_mach", 4'h0, 2'b10, 0, 0, 0, 0, 0, 3, 2'b10, 0, 0, 0, 32'hFFFF_FFFF);
      v[3]  = mk("sts_macl", 4'h0, 2'b01, 0, 0, 0, 0, 0, 3, 2'b01, 0, 0, 0, 32'hFFFF_FFFA);
      v[4]  = mk("muluw",    4'h6, 2'b00, 32'h0001_FFFF, 2, 0, 0, 0, 1, 2'b10, 1, 1, 32'h0002_FFFF, 0);
      v[5]  = mk("sts_macl2",4'h0, 2'b01, 0, 0, 0, 0, 0, 3, 2'b01, 0, 0, 0, 32'h0001_FFFE);
      v[6]  = mk("lds_mach", 4'h8, 2'b10, 0, 0, 0, 0, 0, 1, 2'b10, 1, 1, 0, 0);
      v[7]  = mk("lds_macl", 4'h4, 2'b01, 32'h7FFF_FFFF, 0, 0, 0, 0, 1, 2'b01, 1, 1, 32'h7FFF_FFFF, 0);
      v[8]  = mk("macw",     4'hB, 2'b00, 32'h0002_0002, 32'h0002_0002, 2, 2, 1, 2, 2'b01, 1, 1, 32'h0002_0002, 0);
      v[9]  = mk("sts_macl3",4'h0, 2'b01, 0, 0, 0, 0, 0, 3, 2'b01, 0, 0, 0, 32'h7FFF_FFFF);
      v[10] = mk("sts_mach2",4'h0, 2'b10, 0, 0, 0, 0, 0, 3, 2'b10, 0, 0, 0, 32'h0000_0001);
      v[11] = mk("undef",    4'h5, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      v[12] = mk("lds_macl2",4'h4, 2'b01, 32'h1234_5678, 0, 0, 0, 0, 1, 2'b01, 1, 1, 32'h1234_5678, 0);
      RST_N = 0; RES_N = 1; CE_R = 1; CMD_REQ = 0; CMD_OP = 0; CMD_SEL = 0;
      CMD_A = 0; CMD_B = 0; CMD_AA = 0; CMD_AB = 0; CMD_S = 0;
      repeat (2) @(negedge CLK);
      chk_zero("por");
      RST_N = 1;
      @(negedge CLK);
      // async reset while in B1 of MUL.L
      CMD_OP = 4'h1; CMD_A = 7; CMD_B = 9; CMD_REQ = 1;
      @(posedge CLK);
      #2 RST_N = 0;
      #1 chk_zero("rst_b1");
      @(negedge CLK);
      CMD_REQ = 0; RST_N = 1;
      @(negedge CLK);
      foreach (v[i]) run_cmd(v[i]);
      // soft reset during B1 of MUL.L: MACL must keep 0x12345678
      CMD_OP = 4'h1; CMD_A = 3; CMD_B = 5; CMD_AA = 0; CMD_AB = 0; CMD_REQ = 1;
      @(negedge CLK);
      CMD_REQ = 0;
      chk("resn.b1", 32'({BUSY, MAC_SEL}), 32'b101);
      RES_N = 0;
      @(negedge CLK);
      RES_N = 1;
      chk_zero("resn");
      sts_l = mk("sts_abort", 4'h0, 2'b01, 0, 0, 0, 0, 0, 3, 2'b01, 0, 0, 0, 32'h1234_5678);
      run_cmd(sts_l);
      // CE_R every third CLK with CMD_REQ held for DMULU.L 2*3
      CMD_OP = 4'h2; CMD_A = 2; CMD_B = 3; CMD_AA = 0; CMD_AB = 0; CMD_S = 0; CMD_REQ = 1;
      acks = 0; wide = 0; bad = 0; ackbusy = 0;
      sel_prev = MAC_SEL; ack_prev = 0; ce_prev = 0; busy_prev = BUSY;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) begin
            @(negedge CLK);
            if (MAC_SEL != sel_prev && !ce_prev) bad++;
            if (CMD_ACK) begin
               acks++;
               if (ack_prev) wide++;
               if (busy_prev) ackbusy++;
            end
         end
         sel_prev = MAC_SEL; ack_prev = CMD_ACK; busy_prev = BUSY;
         ce_prev = (i % 3 == 0);
         CE_R = ce_prev;
      end
      chk("ce.freeze", bad, 0);
      chk("ce.ack_width", wide, 0);
      chk("ce.ack_busy", ackbusy, 0);
      chk("ce.ack_count", acks, 2);
      CMD_REQ = 0; CE_R = 1;
      for (int i = 0; i < 10 && BUSY; i++) @(negedge CLK);
      chk("ce.drain", 32'(BUSY), 0);
      sts_l = mk("sts_ce", 4'h0, 2'b01, 0, 0, 0, 0, 0, 3, 2'b01, 0, 0, 0, 32'd6);
      run_cmd(sts_l);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
